imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Program writer for the single-cycle core's instruction memory. Receives a byte stream
//  (16-bit word-count header, then little-endian 32-bit instructions) and writes each word
//  into instruction memory. The core is held in reset until loading completes, then released.
//  Sits between the top-level boot interface and Instruction_Memory / the core's rst input.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of the first written word
//  DEPTH      1024           max words accepted; header count > DEPTH is an error
// PORTS
//  clk         in   1   system clock, all state changes on rising edge
//  rst         in   1   asynchronous, active-low reset
//  byte_valid  in   1   source presents byte_data this cycle
//  byte_data   in   8   stream byte
//  byte_ready  out  1   loader accepts byte; transfer = byte_valid & byte_ready at clk edge
//  imem_we     out  1   one-cycle instruction-memory write strobe
//  imem_addr   out  32  byte address of write, word aligned
//  imem_wdata  out  32  instruction word
//  cpu_rst     out  1   active-low reset to core; 0 until load done
//  done        out  1   load completed successfully (sticky)
//  error       out  1   header count exceeded DEPTH (sticky)
// BEHAVIOUR
//  Reset (rst=0, async): state=HDR_LO; byte_ready=0, imem_we=0, imem_addr=BASE_ADDR,
//   imem_wdata=0, cpu_rst=0, done=0, error=0; counters cleared. byte_ready goes 1 on the
//   first edge after rst is released.
//  States: HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
//   HDR_LO: on transfer, count[7:0]=byte_data -> HDR_HI.
//   HDR_HI: on transfer, count[15:8]=byte_data; count==0 -> DONE; count>DEPTH -> ERR;
//    else -> DATA.
//   DATA: bytes fill word LSB first (byte k -> bits 8k+7:8k); byte-lane counter 0..3.
//    On the 4th transfer -> WRITE.
//   WRITE: exactly one cycle; imem_we=1, imem_addr=BASE_ADDR+4*widx, imem_wdata=assembled
//    word; byte_ready=0 (no transfer possible). widx increments. widx==count -> DONE,
//    else -> DATA with lane counter 0.
//   DONE: byte_ready=0, done=1, cpu_rst=1; remains until rst. Further bytes ignored.
//   ERR: byte_ready=0, error=1, cpu_rst stays 0, imem_we never asserted; remains until rst.
//  Handshake: byte_ready is a registered output, 1 only in HDR_LO/HDR_HI/DATA. byte_valid
//   gaps of any length are legal; no state change without a transfer. byte_data is sampled
//   only on transfer.
//  Latency: imem_we asserts the cycle after the 4th byte of a word is accepted. done and
//   cpu_rst rise the cycle after the last WRITE (or after HDR_HI when count==0).
//  Outputs imem_addr/imem_wdata hold their last value outside WRITE; imem_we=0 outside WRITE.
//  Widths: widx and count are 16 bits; address arithmetic is 32 bits, wraps modulo 2^32.
//  Reset mid-load: all state is discarded; a new header is expected; cpu_rst returns to 0
//   immediately (async).
//  Boundary: count==DEPTH is legal (DEPTH writes). count==DEPTH+1 -> ERR.
// TESTING
//  1. Reset 10 ns then release; stream 02 00, 13 05 50 00, 93 05 A0 00 -> two imem_we
//     pulses: addr 0 data 0x00500513, addr 4 data 0x00A00593; then done=1, cpu_rst=1.
//  2. Header 00 00 -> no imem_we; done=1 and cpu_rst=1 one cycle after 2nd header byte.
//  3. Header with count DEPTH+1 (DEPTH=4: 05 00) -> error=1, byte_ready=0,
//     cpu_rst=0, no writes.
//  4. Random byte_valid gaps (0-5 idle cycles) across a 3-word load -> identical writes to
//     the gap-free run; byte_ready=0 during every WRITE cycle.
//  5. Assert rst after 2 bytes of word 1 -> outputs return to reset values
//     asynchronously; reload 01 00 + 4 bytes -> single write at BASE_ADDR.
//  6. Bytes sent after done -> ignored, no imem_we, done and cpu_rst remain 1.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program writer for the single-cycle core's instruction memory.
// A byte stream arrives over a valid/ready handshake: a 16-bit little-endian
// word count, then that many little-endian 32-bit instructions. Each
// assembled instruction is written to instruction memory with a one-cycle
// strobe. The core is held in reset (cpu_rst low) until every word has been
// written, then released. A word count larger than DEPTH parks the loader in
// a sticky error state with the core still held in reset.
//
// Parameters
//   BASE_ADDR  byte address of the first written word
//   DEPTH      maximum number of words accepted
//
// Ports
//   clk         in   system clock, rising-edge
//   rst         in   asynchronous active-low reset
//   byte_valid  in   source presents byte_data this cycle
//   byte_data   in   stream byte
//   byte_ready  out  loader accepts a byte (registered)
//   imem_we     out  one-cycle instruction-memory write strobe
//   imem_addr   out  word-aligned byte address of the write
//   imem_wdata  out  instruction word being written
//   cpu_rst     out  active-low reset to the core, high once loading is done
//   done        out  load completed successfully (sticky)
//   error       out  header count exceeded DEPTH (sticky)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    // DEPTH widened by one bit so the range check cannot wrap.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state;
    logic [15:0] count;
    logic [15:0] widx;
    logic [1:0]  lane;
    logic [23:0] word;

    logic        xfer;
    logic [15:0] hdr_count;
    logic [15:0] widx_next;

    assign xfer      = byte_valid & byte_ready;
    assign hdr_count = {byte_data, count[7:0]};
    assign widx_next = widx + 16'd1;

    // Byte address of word index idx; 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return BASE_ADDR + {14'd0, idx, 2'b00};
    endfunction

    // Outputs are registered alongside the state: every transition sets the
    // values the outputs must carry while the destination state is current,
    // so byte_ready is already low in the cycle a WRITE begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HDR_LO;
            count      <= '0;
            widx       <= '0;
            lane       <= '0;
            word       <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;

            case (state)
                HDR_LO: begin
                    byte_ready <= 1'b1;
                    if (xfer) begin
                        count[7:0] <= byte_data;
                        state      <= HDR_HI;
                    end
                end

                HDR_HI: begin
                    if (xfer) begin
                        count[15:8] <= byte_data;
                        if (hdr_count == 16'd0) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            cpu_rst    <= 1'b1;
                        end else if ({1'b0, hdr_count} > DEPTH_L) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= DATA;
                            lane  <= 2'd0;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            // Fourth byte goes straight into the write data
                            // so the strobe can follow on the next cycle.
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= word_addr(widx);
                            imem_wdata <= {byte_data, word};
                        end else begin
                            word[8*lane +: 8] <= byte_data;
                        end
                    end
                end

                WRITE: begin
                    widx <= widx_next;
                    lane <= 2'd0;
                    if (widx_next == count) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b1;
                    end else begin
                        state      <= DATA;
                        byte_ready <= 1'b1;
                    end
                end

                DONE: begin
                    byte_ready <= 1'b0;
                    done       <= 1'b1;
                    cpu_rst    <= 1'b1;
                end

                ERR: begin
                    byte_ready <= 1'b0;
                    error      <= 1'b1;
                    cpu_rst    <= 1'b0;
                end

                default: begin
                    state      <= HDR_LO;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader (DEPTH=4, BASE_ADDR=0). Stimulus tasks push
// the expected {addr,data} of every write into a queue; a monitor on the
// falling edge pops and compares each time imem_we is seen.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] prog [0:7];

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=%h/%h required=none",
                         imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, e[63:32]);
                chk("wr_data", imem_wdata, e[31:0]);
                chk("wr_ready_low", {31'd0, byte_ready}, 32'd0);
                chk("wr_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=%b required=1", byte_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Header n, then prog[0..n-1]; expected writes queued as they are sent.
    task automatic load_prog(input int n, input int maxgap);
        send_byte(8'(n), $urandom_range(0, maxgap));
        send_byte(8'(n >> 8), $urandom_range(0, maxgap));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({32'(4 * i), prog[i]});
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                w = prog[i];
                send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, byte_ready}, 32'd1);

        // 1. Two-word load, hand-computed words
        exp_q.push_back({32'h0000_0000, 32'h0050_0513});
        exp_q.push_back({32'h0000_0004, 32'h00A0_0593});
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0);
        send_byte(8'h50, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h05, 0);
        send_byte(8'hA0, 0); send_byte(8'h00, 0);
        chk("t1_done_in_write", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("t1_error", {31'd0, error}, 32'd0);
        chk("t1_last_addr", imem_addr, 32'h0000_0004);
        chk("t1_pending", 32'(exp_q.size()), 32'd0);

        // 6. Bytes after done are ignored
        byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            byte_data = 8'(8'hF0 + i);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("t6_ready", {31'd0, byte_ready}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("t6_wdata_held", imem_wdata, 32'h00A0_0593);

        // 2. Zero-length program
        do_reset();
        send_byte(8'h00, 0);
        chk("t2_done_pre", {31'd0, done}, 32'd0);
        send_byte(8'h00, 0);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("t2_ready", {31'd0, byte_ready}, 32'd0);

        // 3. Count DEPTH+1 -> error
        do_reset();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_ready", {31'd0, byte_ready}, 32'd0);
        chk("t3_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("t3_done", {31'd0, done}, 32'd0);
        byte_valid = 1'b1;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        chk("t3_error_sticky", {31'd0, error}, 32'd1);
        chk("t3_cpu_rst_held", {31'd0, cpu_rst}, 32'd0);

        // Count == DEPTH is legal: four writes at 0,4,8,12
        prog[0] = 32'h0050_0513;
        prog[1] = 32'h00A0_0593;
        prog[2] = 32'h00B5_0633;
        prog[3] = 32'hDEAD_BEEF;
        do_reset();
        load_prog(4, 0);
        wait_done();
        chk("depth_addr", imem_addr, 32'h0000_000C);
        chk("depth_error", {31'd0, error}, 32'd0);
        chk("depth_pending", 32'(exp_q.size()), 32'd0);

        // 4. Three-word load with random valid gaps
        do_reset();
        load_prog(3, 5);
        wait_done();
        chk("t4_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("t4_pending", 32'(exp_q.size()), 32'd0);

        // 5. Reset mid-load, then a one-word reload
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'h1122_3344});
        exp_q.push_back({32'h0000_0004, 32'h5566_7788});
        send_byte(8'h03, 0); send_byte(8'h00, 0);
        send_byte(8'h44, 0); send_byte(8'h33, 0);
        send_byte(8'h22, 0); send_byte(8'h11, 0);
        send_byte(8'h88, 1); send_byte(8'h77, 0);
        send_byte(8'h66, 0); send_byte(8'h55, 0);
        send_byte(8'hAA, 2); send_byte(8'hBB, 0);
        chk("t5_addr_pre", imem_addr, 32'h0000_0004);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_addr", imem_addr, 32'd0);
        chk("t5_async_wdata", imem_wdata, 32'd0);
        chk("t5_async_ready", {31'd0, byte_ready}, 32'd0);
        chk("t5_async_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("t5_pending_pre", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        prog[0] = 32'hCAFE_F00D;
        load_prog(1, 0);
        wait_done();
        chk("t5_addr", imem_addr, 32'h0000_0000);
        chk("t5_wdata", imem_wdata, 32'hCAFE_F00D);
        chk("t5_pending", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
